id_ex_stage: RTL and testbench

//  ID/EX pipeline register directly downstream of the register file. Captures RFRD1/RFRD2 and

---
 rtl/id_ex_stage.sv | 72 +++++++
 tb/tb_id_ex_stage.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with WB bypass, stall hold, flush bubble and saturating bubble counter
module id_ex_stage #(
   parameter int AWL = 5,
   parameter int DWL = 32,
   parameter int CWL = 12,
   parameter int BCW = 16
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           STALL,
   input  logic           FLUSH,
   input  logic           ID_VALID,
   input  logic [AWL-1:0] ID_RA1,
   input  logic [AWL-1:0] ID_RA2,
   input  logic [AWL-1:0] ID_WA,
   input  logic [CWL-1:0] ID_CTRL,
   input  logic [DWL-1:0] ID_IMM,
   input  logic [DWL-1:0] RFRD1,
   input  logic [DWL-1:0] RFRD2,
   input  logic           WB_WE,
   input  logic [AWL-1:0] WB_WA,
   input  logic [DWL-1:0] WB_WD,
   output logic           EX_VALID,
   output logic [DWL-1:0] EX_RD1,
   output logic [DWL-1:0] EX_RD2,
   output logic [AWL-1:0] EX_RA1,
   output logic [AWL-1:0] EX_RA2,
   output logic [AWL-1:0] EX_WA,
   output logic [CWL-1:0] EX_CTRL,
   output logic [DWL-1:0] EX_IMM,
   output logic [BCW-1:0] BUBBLE_CNT
);
   logic [BCW-1:0] bub_next;
   assign bub_next = (BUBBLE_CNT == '1) ? BUBBLE_CNT : BUBBLE_CNT + BCW'(1);
   always_ff @(posedge CLK) begin
      if (RST) begin
         EX_VALID   <= 1'b0;
         EX_RD1     <= '0;
         EX_RD2     <= '0;
         EX_RA1     <= '0;
         EX_RA2     <= '0;
         EX_WA      <= '0;
         EX_CTRL    <= '0;
         EX_IMM     <= '0;
         BUBBLE_CNT <= '0;
      end else if (FLUSH) begin
         EX_VALID   <= 1'b0;
         EX_RD1     <= '0;
         EX_RD2     <= '0;
         EX_RA1     <= '0;
         EX_RA2     <= '0;
         EX_WA      <= '0;
         EX_CTRL    <= '0;
         EX_IMM     <= '0;
         BUBBLE_CNT <= bub_next;
      end else if (STALL) begin
         // held operands must track writebacks that land while EX is frozen
         if (EX_VALID && WB_WE && WB_WA == EX_RA1) EX_RD1 <= WB_WD;
         if (EX_VALID && WB_WE && WB_WA == EX_RA2) EX_RD2 <= WB_WD;
      end else begin
         EX_VALID <= ID_VALID;
         EX_RD1   <= (WB_WE && WB_WA == ID_RA1) ? WB_WD : RFRD1;
         EX_RD2   <= (WB_WE && WB_WA == ID_RA2) ? WB_WD : RFRD2;
         EX_RA1   <= ID_RA1;
         EX_RA2   <= ID_RA2;
         EX_WA    <= ID_WA;
         EX_CTRL  <= ID_VALID ? ID_CTRL : '0;
         EX_IMM   <= ID_IMM;
         if (!ID_VALID) BUBBLE_CNT <= bub_next;
      end
   end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of id_ex_stage load, bypass, stall, flush, reset and counter saturation
module tb_id_ex_stage;
   logic        CLK = 1'b0;
   logic        RST, STALL, FLUSH, ID_VALID, WB_WE;
   logic [4:0]  ID_RA1, ID_RA2, ID_WA, WB_WA;
   logic [11:0] ID_CTRL;
   logic [31:0] ID_IMM, RFRD1, RFRD2, WB_WD;
   logic        EX_VALID, ex4_valid;
   logic [31:0] EX_RD1, EX_RD2, EX_IMM, ex4_rd1, ex4_rd2, ex4_imm;
   logic [4:0]  EX_RA1, EX_RA2, EX_WA, ex4_ra1, ex4_ra2, ex4_wa;
   logic [11:0] EX_CTRL, ex4_ctrl;
   logic [15:0] BUBBLE_CNT;
   logic [3:0]  ex4_bub;
   int checks = 0;
   int errors = 0;
   int exp16, exp4;

   always #5 CLK = ~CLK;

   id_ex_stage dut (
      .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH), .ID_VALID(ID_VALID),
      .ID_RA1(ID_RA1), .ID_RA2(ID_RA2), .ID_WA(ID_WA), .ID_CTRL(ID_CTRL), .ID_IMM(ID_IMM),
      .RFRD1(RFRD1), .RFRD2(RFRD2), .WB_WE(WB_WE), .WB_WA(WB_WA), .WB_WD(WB_WD),
      .EX_VALID(EX_VALID), .EX_RD1(EX_RD1), .EX_RD2(EX_RD2), .EX_RA1(EX_RA1), .EX_RA2(EX_RA2),
      .EX_WA(EX_WA), .EX_CTRL(EX_CTRL), .EX_IMM(EX_IMM), .BUBBLE_CNT(BUBBLE_CNT)
   );

   id_ex_stage #(.BCW(4)) dut4 (
      .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH), .ID_VALID(ID_VALID),
      .ID_RA1(ID_RA1), .ID_RA2(ID_RA2), .ID_WA(ID_WA), .ID_CTRL(ID_CTRL), .ID_IMM(ID_IMM),
      .RFRD1(RFRD1), .RFRD2(RFRD2), .WB_WE(WB_WE), .WB_WA(WB_WA), .WB_WD(WB_WD),
      .EX_VALID(ex4_valid), .EX_RD1(ex4_rd1), .EX_RD2(ex4_rd2), .EX_RA1(ex4_ra1), .EX_RA2(ex4_ra2),
      .EX_WA(ex4_wa), .EX_CTRL(ex4_ctrl), .EX_IMM(ex4_imm), .BUBBLE_CNT(ex4_bub)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic v, input logic [31:0] rd1, input logic [31:0] rd2,
                          input logic [4:0] ra1, input logic [4:0] ra2, input logic [4:0] wa,
                          input logic [11:0] ctrl, input logic [31:0] imm, input logic [15:0] bub);
      chk({tag, ".valid"}, 64'(EX_VALID), 64'(v));
      chk({tag, ".rd1"}, 64'(EX_RD1), 64'(rd1));
      chk({tag, ".rd2"}, 64'(EX_RD2), 64'(rd2));
      chk({tag, ".ra1"}, 64'(EX_RA1), 64'(ra1));
      chk({tag, ".ra2"}, 64'(EX_RA2), 64'(ra2));
      chk({tag, ".wa"}, 64'(EX_WA), 64'(wa));
      chk({tag, ".ctrl"}, 64'(EX_CTRL), 64'(ctrl));
      chk({tag, ".imm"}, 64'(EX_IMM), 64'(imm));
      chk({tag, ".bub"}, 64'(BUBBLE_CNT), 64'(bub));
   endtask

   initial begin
      RST = 1'b1; STALL = 1'($urandom); FLUSH = 1'($urandom); ID_VALID = 1'($urandom);
      ID_RA1 = 5'($urandom); ID_RA2 = 5'($urandom); ID_WA = 5'($urandom);
      ID_CTRL = 12'($urandom); ID_IMM = $urandom; RFRD1 = $urandom; RFRD2 = $urandom;
      WB_WE = 1'($urandom); WB_WA = 5'($urandom); WB_WD = $urandom;
      tick;
      tick;
      chk_all("reset", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("reset.bub4", 64'(ex4_bub), 0);

      RST = 1'b0; STALL = 0; FLUSH = 0; ID_VALID = 1;
      ID_RA1 = 3; ID_RA2 = 4; ID_WA = 9; ID_CTRL = 12'hABC; ID_IMM = 32'hFFFF_FFF0;
      RFRD1 = 32'h11; RFRD2 = 32'h22; WB_WE = 0; WB_WA = 3; WB_WD = 32'hDEAD;
      tick;
      chk_all("load", 1'b1, 32'h11, 32'h22, 3, 4, 9, 12'hABC, 32'hFFFF_FFF0, 0);

      ID_RA1 = 7; ID_RA2 = 7; RFRD1 = 32'hAAAA; RFRD2 = 32'hAAAA;
      WB_WE = 1; WB_WA = 7; WB_WD = 32'h1234;
      tick;
      chk("byp_both.rd1", 64'(EX_RD1), 32'h1234);
      chk("byp_both.rd2", 64'(EX_RD2), 32'h1234);

      ID_RA1 = 0; ID_RA2 = 2; RFRD1 = 32'h99; RFRD2 = 32'h77; WB_WA = 0; WB_WD = 32'h55;
      tick;
      chk("byp_r0.rd1", 64'(EX_RD1), 32'h55);
      chk("byp_r0.rd2", 64'(EX_RD2), 32'h77);

      ID_RA1 = 6; ID_RA2 = 5; ID_WA = 8; ID_CTRL = 12'h123; ID_IMM = 32'h42;
      RFRD1 = 32'h100; RFRD2 = 32'h200; WB_WE = 0;
      tick;
      chk_all("pre_stall", 1'b1, 32'h100, 32'h200, 6, 5, 8, 12'h123, 32'h42, 0);

      STALL = 1; ID_VALID = 0; ID_RA1 = 1; ID_RA2 = 2; ID_WA = 3; ID_CTRL = 12'hFFF;
      ID_IMM = 32'h7; RFRD1 = 32'h1; RFRD2 = 32'h2;
      tick;
      chk_all("stall1", 1'b1, 32'h100, 32'h200, 6, 5, 8, 12'h123, 32'h42, 0);
      WB_WE = 1; WB_WA = 5; WB_WD = 32'hBEEF;
      tick;
      chk("stall2.rd2", 64'(EX_RD2), 32'hBEEF);
      chk("stall2.rd1", 64'(EX_RD1), 32'h100);
      WB_WA = 9; WB_WD = 32'hDEAD;
      tick;
      chk_all("stall3", 1'b1, 32'h100, 32'hBEEF, 6, 5, 8, 12'h123, 32'h42, 0);

      FLUSH = 1;
      tick;
      chk_all("flush_stall", 1'b0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("flush_stall.bub4", 64'(ex4_bub), 1);

      FLUSH = 0; WB_WE = 1; WB_WA = 0; WB_WD = 32'h77;
      tick;
      chk("stall_invalid.rd1", 64'(EX_RD1), 0);
      chk("stall_invalid.bub", 64'(BUBBLE_CNT), 1);

      STALL = 0; WB_WE = 0; ID_RA1 = 10; ID_CTRL = 12'hFFF;
      tick;
      chk("idle.valid", 64'(EX_VALID), 0);
      chk("idle.ctrl", 64'(EX_CTRL), 0);
      chk("idle.ra1", 64'(EX_RA1), 10);
      chk("idle.bub", 64'(BUBBLE_CNT), 2);

      exp16 = 2; exp4 = 2;
      for (int i = 0; i < 20; i++) begin
         tick;
         exp16++;
         exp4 = (exp4 == 15) ? 15 : exp4 + 1;
         chk($sformatf("sat.bub4[%0d]", i), 64'(ex4_bub), 64'(exp4));
      end
      chk("sat.bub16", 64'(BUBBLE_CNT), 64'(exp16));

      ID_VALID = 1; ID_RA1 = 4; ID_RA2 = 11; ID_WA = 12; ID_CTRL = 12'h5A5; ID_IMM = 32'h1000;
      RFRD1 = 32'hCAFE; RFRD2 = 32'hF00D;
      tick;
      chk("pre_rst.valid", 64'(EX_VALID), 1);
      RST = 1; STALL = 1; FLUSH = 1;
      tick;
      chk_all("rst_win", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_win.bub4", 64'(ex4_bub), 0);
      RST = 0; STALL = 0; FLUSH = 0;
      tick;
      chk_all("post_rst", 1'b1, 32'hCAFE, 32'hF00D, 4, 11, 12, 12'h5A5, 32'h1000, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
